// File: rtl/aes_pkg.sv
// Shared AES key-expansion constants: S-box, round constants and the scheduler FSM state type.
package aes_pkg;

  localparam int unsigned AES_NR_MAX = 10;

  typedef enum logic [1:0] {StIdle, StEmit, StFin} ks_state_e;

  // Byte 0x00 is the top byte of the vector.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [79:0] RCON_TBL = 80'h01020408102040801b36;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[(255 - int'(x)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    if (int'(r) < int'(AES_NR_MAX)) begin
      v = RCON_TBL[(9 - int'(r)) * 8 +: 8];
    end
    return v;
  endfunction

endpackage

// File: rtl/key_round.sv
// One AES-128 key-expansion step: derives round key r+1 from round key r.
module key_round
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [3:0]   round_i,
  output logic [127:0] key_o
);

  logic [31:0] w0, w1, w2, w3, rot, sub, t;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    w0  = key_i[127:96];
    w1  = key_i[95:64];
    w2  = key_i[63:32];
    w3  = key_i[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    t   = sub ^ {rcon(round_i), 24'h0};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    key_o = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/key_sched_ctrl.sv
// AES-128 round-key scheduler streaming keys 0..NR over a valid/ready port.
// Define AES_RKEY_STORE_EN to keep every emitted key in a random-access store.
module key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         done,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  localparam logic [3:0] NrIdx = 4'(NR);

  ks_state_e    state_q;
  logic [127:0] key_q, next_key;
  logic [3:0]   idx_q;
  logic         busy_q, valid_q, done_q;
  logic         accept, last;

  key_round u_key_round (
    .key_i   (key_q),
    .round_i (idx_q),
    .key_o   (next_key)
  );

  assign accept = valid_q & rk_ready;
  assign last   = (idx_q == NrIdx);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            key_q   <= key_in;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            state_q <= StEmit;
          end
        end
        StEmit: begin
          if (accept) begin
            if (last) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StFin;
            end else begin
              key_q <= next_key;
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = busy_q;
  assign rk_valid = valid_q;
  assign rk_out   = key_q;
  assign rk_idx   = idx_q;
  assign done     = done_q;

`ifdef AES_RKEY_STORE_EN
  logic [127:0] store_q [NR+1];
  logic [127:0] rd_key_q, rd_key_d, wr_data;
  logic [3:0]   wr_idx;
  logic         wr_en, load;

  // Each key is written in the same edge that makes it visible on rk_out.
  assign load    = (state_q == StIdle) & start;
  assign wr_en   = load | ((state_q == StEmit) & accept & ~last);
  assign wr_idx  = load ? 4'd0 : idx_q + 4'd1;
  assign wr_data = load ? key_in : next_key;

  always_comb begin
    rd_key_d = '0;
    for (int i = 0; i <= int'(NR); i++) begin
      if (int'(rd_idx) == i) rd_key_d = store_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i <= int'(NR); i++) store_q[i] <= '0;
      rd_key_q <= '0;
    end else begin
      for (int i = 0; i <= int'(NR); i++) begin
        if (wr_en && int'(wr_idx) == i) store_q[i] <= wr_data;
      end
      rd_key_q <= rd_key_d;
    end
  end

  assign rd_key = rd_key_q;
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx;
  assign rd_key        = '0;
`endif

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Directed-vector bench for key_sched_ctrl using the FIPS-197 appendix A.1 key expansion.
module tb_key_sched_ctrl;

  localparam int unsigned NR = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         rk_ready = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0]   rd_idx = '0;
  logic         busy, rk_valid, done;
  logic [127:0] rk_out, rd_key;
  logic [3:0]   rk_idx;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] KeyA   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Zero1  = 128'h62636363626363636263636362636363;

  logic [127:0] exp_k [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  key_sched_ctrl #(.NR(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .done     (done),
    .rd_idx   (rd_idx),
    .rd_key   (rd_key)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    step();
    start  = 1'b0;
    key_in = ~k;
  endtask

  // Runs until done is seen (bounded); leaves the bench in the done cycle.
  task automatic drain(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    n_vec++;
    if ({busy, rk_valid, done, rk_idx} !== 7'b0 || rk_out !== '0 || rd_key !== '0) begin
      n_err++;
      $display("FAIL reset_state: flags=%b idx=%0d rk_out=%h rd_key=%h, want all 0",
               {busy, rk_valid, done}, rk_idx, rk_out, rd_key);
    end
    rst = 1'b1;
    key_in = KeyA;
    repeat (3) step();
    n_vec++;
    if ({busy, rk_valid, done, rk_idx} !== 7'b0 || rk_out !== '0) begin
      n_err++;
      $display("FAIL idle_quiet: flags=%b idx=%0d rk_out=%h, want all 0",
               {busy, rk_valid, done}, rk_idx, rk_out);
    end
  endtask

  task automatic test_full_ready();
    rk_ready = 1'b1;
    launch(KeyA);
    for (int i = 0; i <= int'(NR); i++) begin
      n_vec++;
      if ({busy, rk_valid, done} !== 3'b110 || rk_idx !== 4'(i) || rk_out !== exp_k[i]) begin
        n_err++;
        $display("FAIL full_idx%0d: flags=%b idx=%0d key=%h, want flags=110 idx=%0d key=%h",
                 i, {busy, rk_valid, done}, rk_idx, rk_out, i, exp_k[i]);
      end
      step();
    end
    // NR+2 cycles after start
    n_vec++;
    if ({busy, rk_valid, done} !== 3'b001) begin
      n_err++;
      $display("FAIL full_done: flags=%b, want busy=0 valid=0 done=1 (001)",
               {busy, rk_valid, done});
    end
    step();
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse: done=%b one cycle later, want 0", done);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    launch('0);
    n_vec++;
    if (rk_valid !== 1'b1 || rk_idx !== 4'd0 || rk_out !== '0) begin
      n_err++;
      $display("FAIL b2b_start: valid=%b idx=%0d key=%h, want 1 0 0", rk_valid, rk_idx, rk_out);
    end
    step();
    n_vec++;
    if (rk_idx !== 4'd1 || rk_out !== Zero1) begin
      n_err++;
      $display("FAIL b2b_idx1: idx=%0d key=%h, want 1 %h", rk_idx, rk_out, Zero1);
    end
    drain(seen);
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL b2b_done: done=%b, want 1 within cycle budget", done);
    end
    step();
  endtask

  task automatic test_stall();
    int e;
    int c;
    rk_ready = 1'b0;
    launch(KeyA);
    e = 0;
    c = 0;
    while (e <= int'(NR) && c < 60) begin
      n_vec++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'(e) || rk_out !== exp_k[e]) begin
        n_err++;
        $display("FAIL stall_c%0d: valid=%b idx=%0d key=%h, want 1 %0d %h",
                 c, rk_valid, rk_idx, rk_out, e, exp_k[e]);
      end
      rk_ready = c[0];
      step();
      if (rk_ready) e++;
      c++;
    end
    rk_ready = 1'b1;
    n_vec++;
    if (done !== 1'b1 || rk_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_done: done=%b valid=%b after %0d cycles, want 1 0", done, rk_valid, c);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bit seen;
    rk_ready = 1'b1;
    launch(KeyA);
    repeat (5) step();
    n_vec++;
    if (rk_idx !== 4'd5 || rk_out !== exp_k[5]) begin
      n_err++;
      $display("FAIL mid_idx5: idx=%0d key=%h, want 5 %h", rk_idx, rk_out, exp_k[5]);
    end
    rst = 1'b0;
    step();
    n_vec++;
    if ({busy, rk_valid, done, rk_idx} !== 7'b0 || rk_out !== '0 || rd_key !== '0) begin
      n_err++;
      $display("FAIL mid_reset: flags=%b idx=%0d key=%h rd_key=%h, want all 0",
               {busy, rk_valid, done}, rk_idx, rk_out, rd_key);
    end
    rst = 1'b1;
    repeat (2) step();
    n_vec++;
    if ({busy, rk_valid, done, rk_idx} !== 7'b0 || rk_out !== '0) begin
      n_err++;
      $display("FAIL mid_quiet: flags=%b idx=%0d key=%h, want all 0",
               {busy, rk_valid, done}, rk_idx, rk_out);
    end
    launch('0);
    step();
    n_vec++;
    if (rk_idx !== 4'd1 || rk_out !== Zero1) begin
      n_err++;
      $display("FAIL zero_idx1: idx=%0d key=%h, want 1 %h", rk_idx, rk_out, Zero1);
    end
    drain(seen);
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL zero_done: done never seen within cycle budget");
    end
    step();
  endtask

  task automatic test_start_ignored();
    rk_ready = 1'b1;
    launch(KeyA);
    for (int i = 0; i <= int'(NR); i++) begin
      n_vec++;
      if (busy !== 1'b1 || rk_idx !== 4'(i) || rk_out !== exp_k[i]) begin
        n_err++;
        $display("FAIL ign_idx%0d: busy=%b idx=%0d key=%h, want 1 %0d %h",
                 i, busy, rk_idx, rk_out, i, exp_k[i]);
      end
      start  = (i == 3);
      key_in = {128{1'b1}};
      step();
    end
    start = 1'b0;
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL ign_done: done=%b, want 1", done);
    end
    step();
  endtask

  task automatic test_rd_key();
`ifdef AES_RKEY_STORE_EN
    rd_idx = 4'd1;
    step();
    n_vec++;
    if (rd_key !== exp_k[1]) begin
      n_err++;
      $display("FAIL rd_idx1: rd_key=%h, want %h", rd_key, exp_k[1]);
    end
    rd_idx = 4'd10;
    step();
    n_vec++;
    if (rd_key !== exp_k[10]) begin
      n_err++;
      $display("FAIL rd_idx10: rd_key=%h, want %h", rd_key, exp_k[10]);
    end
    rd_idx = 4'd11;
    step();
    n_vec++;
    if (rd_key !== '0) begin
      n_err++;
      $display("FAIL rd_idx11: rd_key=%h, want 0", rd_key);
    end
`else
    logic [3:0] idxs [5] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd15};
    for (int i = 0; i < 5; i++) begin
      rd_idx = idxs[i];
      step();
      n_vec++;
      if (rd_key !== '0) begin
        n_err++;
        $display("FAIL rd_tied%0d: rd_key=%h, want 0", idxs[i], rd_key);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_full_ready();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_start_ignored();
    test_rd_key();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
